// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine for issue slot one: drives the data-side SRAM-like bus,
// forms byte strobes and aligned load results, flags address errors and stalls EX/MEM.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic [1:0]        ls_mem_i,
    input  logic [3:0]        ls_size_mem_i,
    input  logic              ls_signed_mem_i,
    input  logic [ADDR_W-1:0] addr_mem_i,
    input  logic [DATA_W-1:0] store_data_mem_i,
    input  logic              exp_pending_mem_i,
    input  logic              wb_ready,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] load_result,
    output logic              mem_stall,
    output logic              adel,
    output logic              ades,
    output logic [ADDR_W-1:0] bad_vaddr
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t      state;
    logic        is_load, is_store, is_byte, is_half, is_word;
    logic        misaligned, access;
    logic [1:0]  off;
    logic [3:0]  strobe;
    logic [DATA_W-1:0] shifted, load_data;
    logic        unused_size_bit;

    assign off             = addr_mem_i[1:0];
    assign is_load         = (ls_mem_i == 2'b01);
    assign is_store        = (ls_mem_i == 2'b10);
    assign is_byte         = ls_size_mem_i[0];
    assign is_half         = ls_size_mem_i[1];
    assign is_word         = ls_size_mem_i[2];
    assign unused_size_bit = ls_size_mem_i[3];

    assign misaligned = (is_half && off[0]) || (is_word && (off != 2'b00));
    assign access     = (is_load || is_store) && !exp_pending_mem_i && !misaligned && !flush;

    assign adel      = is_load  && misaligned && !exp_pending_mem_i;
    assign ades      = is_store && misaligned && !exp_pending_mem_i;
    assign bad_vaddr = (adel || ades) ? addr_mem_i : '0;

    // Bus attributes come straight from EX/MEM; the stall keeps them frozen while req is held.
    assign data_addr  = addr_mem_i;
    assign data_wr    = is_store;
    assign data_size  = is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd2);
    assign data_wstrb = is_store ? strobe : 4'b0000;
    assign data_wdata = is_byte ? {4{store_data_mem_i[7:0]}} :
                        (is_half ? {2{store_data_mem_i[15:0]}} : store_data_mem_i);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        strobe = 4'b1111;
        if (is_byte)
            strobe = 4'b0001 << off;
        else if (is_half)
            strobe = off[1] ? 4'b1100 : 4'b0011;
    end

    assign shifted = data_rdata >> {off, 3'b000};

    always_comb begin
        load_data = data_rdata;
        if (is_byte)
            load_data = {{24{ls_signed_mem_i & shifted[7]}}, shifted[7:0]};
        else if (is_half)
            load_data = {{16{ls_signed_mem_i & shifted[15]}}, shifted[15:0]};
    end

    assign data_req  = ((state == S_IDLE) && access) || (state == S_REQ);
    assign mem_stall = ((state == S_IDLE) && access) || (state == S_REQ) || (state == S_WAIT) ||
                       ((state == S_DRAIN) && (ls_mem_i != 2'b00));

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous to clk.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            load_result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (access)
                        state <= data_addr_ok ? S_WAIT : S_REQ;
                end
                S_REQ: begin
                    // An accepted request must still be drained even if flushed in the same cycle.
                    if (data_addr_ok)
                        state <= flush ? S_DRAIN : S_WAIT;
                    else if (flush)
                        state <= S_IDLE;
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        if (flush) begin
                            state <= S_IDLE;
                        end else begin
                            if (is_load)
                                load_result <= load_data;
                            state <= S_DONE;
                        end
                    end else if (flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (wb_ready || flush)
                        state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (data_data_ok)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  ls_mem_i = 2'b00;
    logic [3:0]  ls_size_mem_i = 4'b0100;
    logic        ls_signed_mem_i = 1'b0;
    logic [31:0] addr_mem_i = '0;
    logic [31:0] store_data_mem_i = '0;
    logic        exp_pending_mem_i = 1'b0;
    logic        wb_ready = 1'b1;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic [31:0] load_result;
    logic        mem_stall, adel, ades;
    logic [31:0] bad_vaddr;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .ls_mem_i(ls_mem_i), .ls_size_mem_i(ls_size_mem_i), .ls_signed_mem_i(ls_signed_mem_i),
        .addr_mem_i(addr_mem_i), .store_data_mem_i(store_data_mem_i),
        .exp_pending_mem_i(exp_pending_mem_i), .wb_ready(wb_ready),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .load_result(load_result), .mem_stall(mem_stall), .adel(adel), .ades(ades),
        .bad_vaddr(bad_vaddr)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [3:0] s);
        if (s[0]) return 1;
        if (s[1]) return 2;
        return 4;
    endfunction

    function automatic bit ref_misaligned();
        return (int'(addr_mem_i[1:0]) % size_bytes(ls_size_mem_i)) != 0;
    endfunction

    function automatic bit ref_is_ls();
        return (ls_mem_i == 2'b01) || (ls_mem_i == 2'b10);
    endfunction

    function automatic bit ref_access();
        return ref_is_ls() && !exp_pending_mem_i && !ref_misaligned() && !flush;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd);
        int nb;
        logic [31:0] v;
        nb = size_bytes(ls_size_mem_i);
        if (nb == 4) return rd;
        v = rd >> (8 * int'(addr_mem_i[1:0]));
        if (nb == 2) begin
            v = v & 32'h0000FFFF;
            if (ls_signed_mem_i && v >= 32'h8000) v = v - 32'h00010000;
        end else begin
            v = v & 32'h000000FF;
            if (ls_signed_mem_i && v >= 32'h80) v = v - 32'h00000100;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata();
        int nb;
        nb = size_bytes(ls_size_mem_i);
        if (nb == 1) return (store_data_mem_i & 32'hFF) * 32'h01010101;
        if (nb == 2) return (store_data_mem_i & 32'hFFFF) * 32'h00010001;
        return store_data_mem_i;
    endfunction

    function automatic logic [3:0] ref_wstrb();
        int nb, lo;
        logic [3:0] m;
        if (ls_mem_i != 2'b10) return 4'b0000;
        nb = size_bytes(ls_size_mem_i);
        lo = (int'(addr_mem_i[1:0]) / nb) * nb;
        m = '0;
        for (int i = 0; i < 4; i++)
            if (i >= lo && i < lo + nb) m[i] = 1'b1;
        return m;
    endfunction

    // Transaction phases: request not yet accepted, accepted awaiting data (possibly to be
    // discarded), and a completed result held for writeback.
    bit          m_pending, m_inflight, m_drop, m_held, m_held_load;
    logic [31:0] m_result;
    bit          cmp_en = 1'b0;
    bit          e_idle, e_acc, e_req, e_stall, e_mis;

    always @(posedge clk) begin
        if (!resetn) begin
            m_pending = 0; m_inflight = 0; m_drop = 0; m_held = 0; m_held_load = 0;
            m_result = '0;
        end else if (m_held) begin
            if (wb_ready || flush) m_held = 0;
        end else if (m_inflight) begin
            if (data_data_ok) begin
                m_inflight = 0;
                if (!m_drop && !flush) begin
                    m_held = 1;
                    m_held_load = (ls_mem_i == 2'b01);
                    if (m_held_load) m_result = ref_load(data_rdata);
                end
                m_drop = 0;
            end else if (flush) begin
                m_drop = 1;
            end
        end else if (m_pending) begin
            if (data_addr_ok) begin
                m_pending = 0; m_inflight = 1; m_drop = flush;
            end else if (flush) begin
                m_pending = 0;
            end
        end else if (ref_access()) begin
            if (data_addr_ok) m_inflight = 1;
            else m_pending = 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            e_idle  = !(m_pending || m_inflight || m_held);
            e_acc   = ref_access();
            e_mis   = ref_is_ls() && ref_misaligned() && !exp_pending_mem_i;
            e_req   = (e_idle && e_acc) || m_pending;
            e_stall = (e_idle && e_acc) || m_pending || (m_inflight && !m_drop) ||
                      (m_inflight && m_drop && ls_mem_i != 2'b00);
            check("m.data_req", data_req, e_req);
            check("m.mem_stall", mem_stall, e_stall);
            check("m.adel", adel, e_mis && ls_mem_i == 2'b01);
            check("m.ades", ades, e_mis && ls_mem_i == 2'b10);
            check("m.bad_vaddr", bad_vaddr, e_mis ? addr_mem_i : 32'h0);
            check("m.data_wr", data_wr, ls_mem_i == 2'b10);
            check("m.data_size", data_size, size_bytes(ls_size_mem_i) / 2);
            check("m.data_addr", data_addr, addr_mem_i);
            check("m.data_wstrb", data_wstrb, ref_wstrb());
            check("m.data_wdata", data_wdata, ref_wdata());
            if (m_held && m_held_load) check("m.load_result", load_result, m_result);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_ins(input logic [1:0] ls, input logic [3:0] sz, input logic sgn,
                           input logic [31:0] a, input logic [31:0] wd);
        ls_mem_i = ls; ls_size_mem_i = sz; ls_signed_mem_i = sgn;
        addr_mem_i = a; store_data_mem_i = wd;
    endtask

    task automatic set_bus(input logic ao, input logic dok, input logic [31:0] rd);
        data_addr_ok = ao; data_data_ok = dok; data_rdata = rd;
    endtask

    task automatic idle_inputs();
        set_ins(2'b00, 4'b0100, 1'b0, 32'h0, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0);
        flush = 1'b0; wb_ready = 1'b1; exp_pending_mem_i = 1'b0;
    endtask

    task automatic run_load(input string name, input logic [3:0] sz, input logic sgn,
                            input logic [31:0] a, input logic [31:0] rd, input logic [31:0] exp);
        tick(); set_ins(2'b01, sz, sgn, a, 32'h0); set_bus(1'b1, 1'b0, 32'h0); settle();
        tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
        tick(); set_bus(1'b0, 1'b1, rd); settle();
        tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
        check(name, load_result, exp);
        tick(); idle_inputs(); settle();
    endtask

    task automatic run_store(input string name, input logic [3:0] sz, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] strb,
                             input logic [31:0] wd, input logic [1:0] dsz);
        tick(); set_ins(2'b10, sz, 1'b0, a, d); set_bus(1'b1, 1'b0, 32'h0); settle();
        check({name, ".wr"}, data_wr, 1'b1);
        check({name, ".wstrb"}, data_wstrb, strb);
        check({name, ".wdata"}, data_wdata, wd);
        check({name, ".size"}, data_size, dsz);
        tick(); set_bus(1'b0, 1'b1, 32'h0); settle();
        tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
        check({name, ".done_stall"}, mem_stall, 1'b0);
        tick(); idle_inputs(); settle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        resetn = 1'b0;
        tick();
        cmp_en = 1'b1;
        settle();
        check("reset.data_req", data_req, 1'b0);
        check("reset.mem_stall", mem_stall, 1'b0);
        check("reset.load_result", load_result, 32'h0);
        tick(); resetn = 1'b1; settle();

        // Word load: addr_ok cycle 0, data_ok cycle 2, result in DONE on cycle 3.
        tick(); set_ins(2'b01, 4'b0100, 1'b0, 32'h80001004, 32'h0); set_bus(1'b1, 1'b0, 32'h0); settle();
        check("lw.c0.req", data_req, 1'b1);
        check("lw.c0.stall", mem_stall, 1'b1);
        check("lw.c0.addr", data_addr, 32'h80001004);
        tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
        check("lw.c1.req", data_req, 1'b0);
        check("lw.c1.stall", mem_stall, 1'b1);
        tick(); set_bus(1'b0, 1'b1, 32'hDEADBEEF); settle();
        check("lw.c2.req", data_req, 1'b0);
        check("lw.c2.stall", mem_stall, 1'b1);
        tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
        check("lw.c3.stall", mem_stall, 1'b0);
        check("lw.c3.result", load_result, 32'hDEADBEEF);
        tick(); idle_inputs(); settle();

        // Sub-word loads.
        run_load("lb.signed",   4'b0001, 1'b1, 32'h00000103, 32'h80FFFFFF, 32'hFFFFFF80);
        run_load("lbu",         4'b0001, 1'b0, 32'h00000103, 32'h80FFFFFF, 32'h00000080);
        run_load("lh.signed",   4'b0010, 1'b1, 32'h00000402, 32'h80011234, 32'hFFFF8001);
        run_load("lhu.low",     4'b0010, 1'b0, 32'h00000400, 32'h1234F00D, 32'h0000F00D);
        run_load("lb.pos.lane1", 4'b0001, 1'b1, 32'h00000501, 32'h00007F00, 32'h0000007F);

        // Stores.
        run_store("sb", 4'b0001, 32'h00000601, 32'h000000AB, 4'b0010, 32'hABABABAB, 2'd0);
        run_store("sh", 4'b0010, 32'h00000602, 32'h12345678, 4'b1100, 32'h56785678, 2'd1);
        run_store("sw", 4'b0100, 32'h00000604, 32'hCAFEBABE, 4'b1111, 32'hCAFEBABE, 2'd2);

        // Misaligned and suppressed accesses.
        tick(); set_ins(2'b01, 4'b0100, 1'b0, 32'h00000102, 32'h0); set_bus(1'b1, 1'b0, 32'h0); settle();
        check("mis.lw.adel", adel, 1'b1);
        check("mis.lw.bad_vaddr", bad_vaddr, 32'h00000102);
        check("mis.lw.req", data_req, 1'b0);
        check("mis.lw.stall", mem_stall, 1'b0);
        tick(); settle();
        check("mis.lw.req2", data_req, 1'b0);
        tick(); set_ins(2'b10, 4'b0010, 1'b0, 32'h00000201, 32'h1111); settle();
        check("mis.sh.ades", ades, 1'b1);
        check("mis.sh.adel", adel, 1'b0);
        check("mis.sh.req", data_req, 1'b0);
        tick(); set_ins(2'b01, 4'b0100, 1'b0, 32'h00000102, 32'h0); exp_pending_mem_i = 1'b1; settle();
        check("exp.adel", adel, 1'b0);
        check("exp.req", data_req, 1'b0);
        check("exp.bad_vaddr", bad_vaddr, 32'h0);
        tick(); idle_inputs(); settle();

        // addr_ok held low for 3 cycles: request and address stay put.
        tick(); set_ins(2'b01, 4'b0100, 1'b0, 32'h00002000, 32'h0); settle();
        check("req.c0.req", data_req, 1'b1);
        for (int i = 1; i < 3; i++) begin
            tick(); settle();
            check("req.hold.req", data_req, 1'b1);
            check("req.hold.stall", mem_stall, 1'b1);
            check("req.hold.addr", data_addr, 32'h00002000);
        end
        tick(); set_bus(1'b1, 1'b0, 32'h0); settle();
        check("req.acc.req", data_req, 1'b1);
        tick(); set_bus(1'b0, 1'b1, 32'hCAFEF00D); settle();
        check("req.wait.req", data_req, 1'b0);
        tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
        check("req.done.result", load_result, 32'hCAFEF00D);
        tick(); idle_inputs(); settle();

        // Flush on the 2nd cycle of an unaccepted request.
        tick(); set_ins(2'b01, 4'b0100, 1'b0, 32'h00002100, 32'h0); settle();
        tick(); flush = 1'b1; settle();
        check("rflush.c1.req", data_req, 1'b1);
        tick(); idle_inputs(); settle();
        check("rflush.c2.req", data_req, 1'b0);
        check("rflush.c2.stall", mem_stall, 1'b0);
        run_load("after.rflush", 4'b0100, 1'b0, 32'h00002104, 32'h55AA55AA, 32'h55AA55AA);

        // Flush in WAIT; stale data_ok two cycles later while a new load waits.
        tick(); set_ins(2'b01, 4'b0100, 1'b0, 32'h00003000, 32'h0); set_bus(1'b1, 1'b0, 32'h0); settle();
        tick(); set_bus(1'b0, 1'b0, 32'h0); flush = 1'b1; settle();
        check("wflush.c1.stall", mem_stall, 1'b1);
        tick(); flush = 1'b0; set_ins(2'b01, 4'b0100, 1'b0, 32'h00003004, 32'h0); settle();
        check("drain.c2.req", data_req, 1'b0);
        check("drain.c2.stall", mem_stall, 1'b1);
        tick(); set_bus(1'b0, 1'b1, 32'hBADBAD00); settle();
        check("drain.c3.req", data_req, 1'b0);
        check("drain.c3.stall", mem_stall, 1'b1);
        tick(); set_bus(1'b1, 1'b0, 32'h0); settle();
        check("drain.new.req", data_req, 1'b1);
        check("drain.new.addr", data_addr, 32'h00003004);
        check("drain.stale", load_result, 32'h55AA55AA);
        tick(); set_bus(1'b0, 1'b1, 32'h11223344); settle();
        tick(); set_bus(1'b0, 1'b0, 32'h0); settle();
        check("drain.new.result", load_result, 32'h11223344);
        check("drain.new.stall", mem_stall, 1'b0);
        tick(); idle_inputs(); settle();

        // Flush and data_ok together in WAIT, then DONE held without wb_ready.
        tick(); set_ins(2'b01, 4'b0100, 1'b0, 32'h00004000, 32'h0); set_bus(1'b1, 1'b0, 32'h0); settle();
        tick(); set_bus(1'b0, 1'b1, 32'h99999999); flush = 1'b1; settle();
        check("fdok.stall", mem_stall, 1'b1);
        tick(); idle_inputs(); settle();
        check("fdok.idle.stall", mem_stall, 1'b0);
        check("fdok.discard", load_result, 32'h11223344);
        tick(); set_ins(2'b01, 4'b0001, 1'b0, 32'h00004006, 32'h0); set_bus(1'b1, 1'b0, 32'h0); settle();
        check("hold.issue.req", data_req, 1'b1);
        tick(); set_bus(1'b0, 1'b1, 32'h00A50000); settle();
        tick(); set_bus(1'b0, 1'b0, 32'h0); wb_ready = 1'b0; settle();
        check("hold.d0.result", load_result, 32'h000000A5);
        tick(); settle();
        check("hold.d1.stall", mem_stall, 1'b0);
        check("hold.d1.req", data_req, 1'b0);
        check("hold.d1.result", load_result, 32'h000000A5);
        tick(); wb_ready = 1'b1; settle();
        tick(); idle_inputs(); settle();

        // Reset in the middle of a transaction.
        tick(); set_ins(2'b01, 4'b0100, 1'b0, 32'h00005000, 32'h0); set_bus(1'b1, 1'b0, 32'h0); settle();
        tick(); idle_inputs(); resetn = 1'b0; settle();
        check("rst.wait.stall", mem_stall, 1'b1);
        tick(); resetn = 1'b1; settle();
        check("rst.after.stall", mem_stall, 1'b0);
        check("rst.after.req", data_req, 1'b0);
        check("rst.after.result", load_result, 32'h0);
        tick(); settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
